jam_cost_loader: RTL

JAM_COST_LOADER -- requirements
Module: jam_cost_loader

---
 rtl/jam_cost_loader.sv | 57 +++++
 1 files changed

// File: rtl/jam_cost_loader.sv
// jam_cost_loader: streams a row-major 8x8 cost table into storage and accumulates the sum of row minima as a lower bound for JAM.
module jam_cost_loader #(
  parameter int COST_W = 7,
  parameter int LB_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              Reload,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              Loaded,
  output logic [LB_W-1:0]   LowerBound
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  logic [1:0]        state;
  logic [5:0]        idx;
  logic [COST_W-1:0] mem [64];
  logic [COST_W-1:0] rmin;
  logic [COST_W-1:0] row_min;
  logic [LB_W-1:0]   acc;
  logic              accept;
  assign in_ready   = state != READY;
  assign accept     = in_valid & in_ready & ~Reload;
  assign row_min    = (idx[2:0] == 3'd0 || in_data < rmin) ? in_data : rmin;
  assign Loaded     = state == READY;
  assign Cost       = Loaded ? mem[{W, J}] : '0;
  assign LowerBound = Loaded ? acc : '0;
  // Load control: beat index, running row minimum and the lower-bound accumulator; Reload always wins over a beat.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      rmin  <= '0;
      acc   <= '0;
    end else if (Reload) begin
      state <= IDLE;
      idx   <= '0;
      rmin  <= '0;
      acc   <= '0;
    end else if (accept) begin
      idx   <= idx + 6'd1;
      rmin  <= row_min;
      state <= idx == 6'd63 ? READY : LOAD;
      if (idx[2:0] == 3'd7) acc <= acc + {{(LB_W-COST_W){1'b0}}, row_min};
    end
  end
  // Table storage is never cleared; stale contents are masked by Loaded.
  always_ff @(negedge CLK) begin
    if (accept) mem[idx] <= in_data;
  end
endmodule
